pipe_skid_stage: RTL and testbench
==================================

Name: pipe_skid_stage

Overview:
- Parametrised pipeline stage register that replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers with one generic block.
- Uses a valid/ready handshake and carries an opaque DATA_W payload plus a halt sideband bit.
- Optional skid slot: when enabled, in_ready is fully registered, so a downstream stall does not form a combinational path back up the pipe.
- Adds squash (flush) with discard accounting, a sticky halt that blocks new intake, and saturating stall/squash counters for performance analysis.

Parameters:
- DATA_W, 32, payload width in bits; covers PC, instruction, control and operands as packed by the instantiating stage.
- CNT_W, 16, width of each performance counter.
- SKID_EN, 1, 1 = two slots (main + skid) with registered in_ready; 0 = single slot with pass-through ready.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream holds a valid entry.
- in_ready  out  1  stage accepts an entry this cycle.
- in_data  in  DATA_W  upstream payload.
- in_halt  in  1  upstream entry is a halt.
- squash  in  1  discard all held entries and the same-cycle input.
- out_valid  out  1  main slot holds a valid entry.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  main-slot payload.
- out_halt  out  1  main-slot halt bit.
- halt_seen  out  1  sticky: a halt entry has been accepted.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.
- squash_cnt  out  CNT_W  valid entries discarded by squash.

Behaviour:
- Reset (rst=0, asynchronous): state EMPTY; out_valid=0; out_data=0; out_halt=0; skid slot cleared; halt_seen=0; both counters 0. in_ready reads 1 from the first cycle after reset deasserts.
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States (SKID_EN=1): EMPTY, ONE (main slot full), TWO (main and skid slots full).
- SKID_EN=1 ready: in_ready = (state!=TWO) & !halt_seen. It depends only on registered state, never on out_ready.
- SKID_EN=0 ready: in_ready = ((state==EMPTY) | out_ready) & !halt_seen. State TWO is unreachable.
- Transitions when squash=0:
  - EMPTY: in_fire → ONE, main<=in.
  - ONE: in_fire & out_fire → ONE, main<=in. out_fire only → EMPTY. in_fire only → TWO, skid<=in (SKID_EN=1). Neither → hold.
  - TWO: out_fire → ONE, main<=skid. Otherwise hold.
- Ordering: strict FIFO. Latency from in_fire to out_valid is exactly 1 cycle when the stage is empty.
- Idle slots: payload registers of empty slots hold their last value; their contents are don't-care.
- Squash:
  - Highest priority: next state EMPTY and halt_seen<=0. An in_fire in the same cycle is not captured.
  - out_valid is not masked in the squash cycle. If out_fire occurs, that entry counts as delivered.
  - squash_cnt += (valid entries held) − (out_fire ? 1 : 0). The increment is therefore 0, 1 or 2.
- Halt: halt_seen<=1 on an in_fire with in_halt=1. in_ready stays 0 until squash or reset, while held entries continue to drain normally.
- Counters: stall_cnt += 1 whenever out_valid & !out_ready, including squash cycles. Both counters saturate at all-ones and do not wrap.
- Simultaneous events:
  - Saturated counter with a new increment: the counter holds its value.
  - halt accepted and squash in the same cycle: squash wins, so halt_seen=0.
  - rst asserted mid-transfer: all state is dropped immediately and is not counted as squash.

Decomposition:
- pipe_pkg: state enum {EMPTY, ONE, TWO} and the counter increment width constant.
- One natural sub-module: sat_counter (parameter CNT_W; ports clk, rst, inc[1:0], count). It is instantiated twice.

Test Plan:
1. SKID_EN=1, out_ready=1. Stream payloads 0x10, 0x11, 0x12 on consecutive cycles → each appears on out_data one cycle later, in_ready stays 1, stall_cnt=0.
2. out_ready=0. Push 0xA then 0xB → state TWO and in_ready=0 with no combinational dependence on out_ready. Raise out_ready → 0xA then 0xB delivered, stall_cnt=2.
3. State TWO, squash=1 with out_ready=0 → EMPTY next cycle, squash_cnt=2. Repeat with out_ready=1 → squash_cnt increases by 1.
4. Accept an entry with in_halt=1 → halt_seen=1, in_ready=0, and a later in_valid is ignored. Then squash → halt_seen=0, in_ready=1.
5. CNT_W=4 with out_ready held low for 20 cycles → stall_cnt=15 and holds there.
6. SKID_EN=0: full with out_ready=1 and in_valid=1 → in_ready=1 and the slot is replaced the same cycle. Pulse rst low mid-stream → all outputs return to reset values at once.

Source files
------------

// File: rtl/pipe_pkg.sv
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared types and constants for the generic pipeline stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  // Up to two entries can be discarded or stalled per cycle.
  localparam int c_inc_w = 2;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Purpose  : Performance counter that adds 0..3 per cycle and sticks at all-ones.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [c_inc_w-1:0] inc,
  output logic [CNT_W-1:0]   count
);

  localparam logic [CNT_W-1:0] c_max = '1;

  logic [CNT_W-1:0] r_count;
  logic [CNT_W:0]   w_sum;

  // One extra bit catches any overflow so the result clamps instead of wrapping.
  assign w_sum = {1'b0, r_count} + {{(CNT_W + 1 - c_inc_w){1'b0}}, inc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_sum > {1'b0, c_max}) begin
      r_count <= c_max;
    end else begin
      r_count <= w_sum[CNT_W-1:0];
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipe_skid_stage.sv
// ============================================================================
// Module   : pipe_skid_stage
// Purpose  : Generic valid/ready pipeline register with optional skid slot,
//            squash, sticky halt and saturating stall/squash counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_halt,
  input  logic              squash,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_halt,
  output logic              halt_seen,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  squash_cnt
);

  pipe_state_t       r_state;
  pipe_state_t       w_state_nxt;
  logic [DATA_W-1:0] r_main_data;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_main_halt;
  logic              r_skid_halt;
  logic              r_halt_seen;

  logic              w_in_ready;
  logic              w_in_fire;
  logic              w_out_valid;
  logic              w_out_fire;
  logic              w_load_main_in;
  logic              w_load_main_skid;
  logic              w_load_skid;
  logic [c_inc_w-1:0] w_held;
  logic [c_inc_w-1:0] w_stall_inc;
  logic [c_inc_w-1:0] w_squash_inc;

  assign w_out_valid = (r_state != EMPTY);

  generate
    if (SKID_EN) begin : g_skid_ready
      // Registered-only ready: no path from out_ready back to in_ready.
      assign w_in_ready = (r_state != TWO) & ~r_halt_seen;
    end else begin : g_pass_ready
      assign w_in_ready = ((r_state == EMPTY) | out_ready) & ~r_halt_seen;
    end
  endgenerate

  assign w_in_fire  = in_valid & w_in_ready;
  assign w_out_fire = w_out_valid & out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (squash) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt    = ONE;
            w_load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_load_main_in = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = EMPTY;
          end else if (w_in_fire && SKID_EN) begin
            w_state_nxt = TWO;
            w_load_skid = 1'b1;
          end
        end
        TWO: begin
          if (w_out_fire) begin
            w_state_nxt      = ONE;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= EMPTY;
      r_main_data <= '0;
      r_main_halt <= 1'b0;
      r_skid_data <= '0;
      r_skid_halt <= 1'b0;
      r_halt_seen <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_main_in) begin
        r_main_data <= in_data;
        r_main_halt <= in_halt;
      end else if (w_load_main_skid) begin
        r_main_data <= r_skid_data;
        r_main_halt <= r_skid_halt;
      end
      if (w_load_skid) begin
        r_skid_data <= in_data;
        r_skid_halt <= in_halt;
      end
      // Squash clears halt even if a halt entry is offered in the same cycle.
      if (squash) begin
        r_halt_seen <= 1'b0;
      end else if (w_in_fire && in_halt) begin
        r_halt_seen <= 1'b1;
      end
    end
  end

  // An entry delivered during the squash cycle is not counted as discarded.
  assign w_held       = (r_state == TWO) ? 2'd2 : ((r_state == ONE) ? 2'd1 : 2'd0);
  assign w_squash_inc = squash ? (w_held - {1'b0, w_out_fire}) : 2'd0;
  assign w_stall_inc  = {1'b0, w_out_valid & ~out_ready};

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_squash_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_squash_inc),
    .count (squash_cnt)
  );

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_main_data;
  assign out_halt  = r_main_halt;
  assign halt_seen = r_halt_seen;

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
// ============================================================================
// Module   : tb_pipe_skid_stage
// Purpose  : Self-checking bench: skid instance (CNT_W=16) and pass-through
//            instance (CNT_W=4), vector table, corner sequences, random model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_skid_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, a_in_valid, a_in_ready, a_in_halt, a_squash;
  logic        a_out_valid, a_out_ready, a_out_halt, a_halt_seen;
  logic [31:0] a_in_data, a_out_data;
  logic [15:0] a_stall_cnt, a_squash_cnt;

  logic        rst_b, b_in_valid, b_in_ready, b_in_halt, b_squash;
  logic        b_out_valid, b_out_ready, b_out_halt, b_halt_seen;
  logic [31:0] b_in_data, b_out_data;
  logic [3:0]  b_stall_cnt, b_squash_cnt;

  pipe_skid_stage #(.DATA_W(32), .CNT_W(16), .SKID_EN(1'b1)) u_dut_a (
    .clk(clk), .rst(rst_a), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_halt(a_in_halt), .squash(a_squash),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_halt(a_out_halt), .halt_seen(a_halt_seen),
    .stall_cnt(a_stall_cnt), .squash_cnt(a_squash_cnt)
  );

  pipe_skid_stage #(.DATA_W(32), .CNT_W(4), .SKID_EN(1'b0)) u_dut_b (
    .clk(clk), .rst(rst_b), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_halt(b_in_halt), .squash(b_squash),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_halt(b_out_halt), .halt_seen(b_halt_seen),
    .stall_cnt(b_stall_cnt), .squash_cnt(b_squash_cnt)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Payload fields are compared only when an entry is expected to be visible.
  function automatic logic [127:0] pack(input logic irdy, input logic ov, input logic [31:0] od,
                                        input logic oh, input logic hs, input logic [15:0] st,
                                        input logic [15:0] sc, input logic chk);
    return {60'b0, irdy, ov, (chk ? od : 32'h0), (chk ? oh : 1'b0), hs, st, sc};
  endfunction

  function automatic logic [127:0] pack_a(input logic chk);
    return pack(a_in_ready, a_out_valid, a_out_data, a_out_halt, a_halt_seen,
                a_stall_cnt, a_squash_cnt, chk);
  endfunction

  function automatic logic [127:0] pack_b(input logic chk);
    return pack(b_in_ready, b_out_valid, b_out_data, b_out_halt, b_halt_seen,
                {12'b0, b_stall_cnt}, {12'b0, b_squash_cnt}, chk);
  endfunction

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ih;
    logic        sq;
    logic        ordy;
    logic        irdy;
    logic        ov;
    logic [31:0] od;
    logic        oh;
    logic        hs;
    logic [15:0] st;
    logic [15:0] sc;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [31:0] id, input logic ih,
                              input logic sq, input logic ordy, input logic irdy,
                              input logic ov, input logic [31:0] od, input logic oh,
                              input logic hs, input logic [15:0] st, input logic [15:0] sc);
    vec_t v;
    v.iv = iv; v.id = id; v.ih = ih; v.sq = sq; v.ordy = ordy;
    v.irdy = irdy; v.ov = ov; v.od = od; v.oh = oh; v.hs = hs; v.st = st; v.sc = sc;
    return v;
  endfunction

  localparam int c_nvec = 22;
  vec_t vecs[c_nvec];

  // Reference model: each instance is a bounded FIFO of {halt, data}.
  logic [32:0] m_q[2][2];
  int          m_cnt[2];
  bit          m_halt[2];
  int          m_st[2];
  int          m_sc[2];

  logic        r_iv[2], r_ih[2], r_sq[2], r_ordy[2];
  logic [31:0] r_id[2];

  task automatic idle_a();
    a_in_valid = 1'b0; a_in_data = '0; a_in_halt = 1'b0; a_squash = 1'b0; a_out_ready = 1'b0;
  endtask

  task automatic idle_b();
    b_in_valid = 1'b0; b_in_data = '0; b_in_halt = 1'b0; b_squash = 1'b0; b_out_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] act;
    logic [127:0] exp;
    bit           irdy_e, ov_e, in_f, out_f;
    int           maxc;

    // Test 1: streaming with out_ready=1
    vecs[0]  = mk(1, 32'h10, 0, 0, 1,  1, 0, 32'h00, 0, 0, 0, 0);
    vecs[1]  = mk(1, 32'h11, 0, 0, 1,  1, 1, 32'h10, 0, 0, 0, 0);
    vecs[2]  = mk(1, 32'h12, 0, 0, 1,  1, 1, 32'h11, 0, 0, 0, 0);
    vecs[3]  = mk(0, 32'h00, 0, 0, 1,  1, 1, 32'h12, 0, 0, 0, 0);
    // Test 2: fill both slots under stall, then drain
    vecs[4]  = mk(1, 32'h0A, 0, 0, 0,  1, 0, 32'h00, 0, 0, 0, 0);
    vecs[5]  = mk(1, 32'h0B, 0, 0, 0,  1, 1, 32'h0A, 0, 0, 0, 0);
    vecs[6]  = mk(0, 32'h00, 0, 0, 0,  0, 1, 32'h0A, 0, 0, 1, 0);
    vecs[7]  = mk(1, 32'h0C, 0, 0, 1,  0, 1, 32'h0A, 0, 0, 2, 0);
    vecs[8]  = mk(0, 32'h00, 0, 0, 1,  1, 1, 32'h0B, 0, 0, 2, 0);
    // Test 3: squash from TWO, without and with a same-cycle delivery
    vecs[9]  = mk(1, 32'h20, 0, 0, 0,  1, 0, 32'h00, 0, 0, 2, 0);
    vecs[10] = mk(1, 32'h21, 0, 0, 0,  1, 1, 32'h20, 0, 0, 2, 0);
    vecs[11] = mk(0, 32'h00, 0, 1, 0,  0, 1, 32'h20, 0, 0, 3, 0);
    vecs[12] = mk(1, 32'h30, 0, 0, 0,  1, 0, 32'h00, 0, 0, 4, 2);
    vecs[13] = mk(1, 32'h31, 0, 0, 0,  1, 1, 32'h30, 0, 0, 4, 2);
    vecs[14] = mk(0, 32'h00, 0, 1, 1,  0, 1, 32'h30, 0, 0, 5, 2);
    // Test 4: sticky halt, drain, squash clears; halt+squash together
    vecs[15] = mk(1, 32'h40, 1, 0, 0,  1, 0, 32'h00, 0, 0, 5, 3);
    vecs[16] = mk(1, 32'h41, 0, 0, 0,  0, 1, 32'h40, 1, 1, 5, 3);
    vecs[17] = mk(1, 32'h42, 0, 0, 1,  0, 1, 32'h40, 1, 1, 6, 3);
    vecs[18] = mk(1, 32'h43, 0, 0, 1,  0, 0, 32'h00, 0, 1, 6, 3);
    vecs[19] = mk(0, 32'h00, 0, 1, 1,  0, 0, 32'h00, 0, 1, 6, 3);
    vecs[20] = mk(1, 32'h50, 1, 1, 1,  1, 0, 32'h00, 0, 0, 6, 3);
    vecs[21] = mk(0, 32'h00, 0, 0, 1,  1, 0, 32'h00, 0, 0, 6, 3);

    idle_a(); idle_b();
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    #1;
    check("reset_a", pack_a(1'b1), pack(1, 0, 32'h0, 0, 0, 16'h0, 16'h0, 1'b1));
    check("reset_b", pack_b(1'b1), pack(1, 0, 32'h0, 0, 0, 16'h0, 16'h0, 1'b1));

    for (int i = 0; i < c_nvec; i++) begin
      @(negedge clk);
      a_in_valid = vecs[i].iv; a_in_data = vecs[i].id; a_in_halt = vecs[i].ih;
      a_squash = vecs[i].sq; a_out_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d", i), pack_a(vecs[i].ov),
            pack(vecs[i].irdy, vecs[i].ov, vecs[i].od, vecs[i].oh, vecs[i].hs,
                 vecs[i].st, vecs[i].sc, vecs[i].ov));
    end
    @(negedge clk);
    idle_a();

    // Test 6: pass-through ready lets a full slot be replaced in one cycle
    b_in_valid = 1'b1; b_in_data = 32'h55; b_out_ready = 1'b1;
    #1;
    check("b_empty_rdy", {127'b0, b_in_ready}, 128'd1);
    @(negedge clk);
    b_in_data = 32'h66;
    #1;
    check("b_replace", {94'b0, b_out_valid, b_in_ready, b_out_data}, {94'b0, 2'b11, 32'h55});
    @(negedge clk);
    b_in_data = 32'h77; b_out_ready = 1'b0;
    #1;
    check("b_full_block", {94'b0, b_out_valid, b_in_ready, b_out_data}, {94'b0, 2'b10, 32'h66});
    // Test 5: a long stall saturates the 4-bit counter
    b_in_valid = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("b_stall_sat", {124'b0, b_stall_cnt}, 128'd15);
    @(negedge clk);
    #1;
    check("b_stall_hold", {92'b0, b_stall_cnt, b_out_data}, {92'b0, 4'd15, 32'h66});
    // Asynchronous reset pulse in the middle of traffic
    @(negedge clk);
    b_in_valid = 1'b1; b_in_data = 32'h88; b_out_ready = 1'b1;
    #2;
    rst_b = 1'b0;
    #1;
    check("b_async_rst", pack_b(1'b1), pack(1, 0, 32'h0, 0, 0, 16'h0, 16'h0, 1'b1));
    @(negedge clk);
    idle_b();

    // Randomized traffic on both instances against the FIFO model
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_halt[k] = 0; m_st[k] = 0; m_sc[k] = 0;
    end

    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        r_iv[k]   = ($urandom_range(0, 3) != 0);
        r_id[k]   = $urandom;
        r_ih[k]   = ($urandom_range(0, 31) == 0);
        r_sq[k]   = ($urandom_range(0, 15) == 0);
        r_ordy[k] = $urandom_range(0, 1);
      end
      a_in_valid = r_iv[0]; a_in_data = r_id[0]; a_in_halt = r_ih[0];
      a_squash = r_sq[0]; a_out_ready = r_ordy[0];
      b_in_valid = r_iv[1]; b_in_data = r_id[1]; b_in_halt = r_ih[1];
      b_squash = r_sq[1]; b_out_ready = r_ordy[1];
      #1;
      for (int k = 0; k < 2; k++) begin
        maxc   = (k == 0) ? 65535 : 15;
        irdy_e = ((k == 0) ? (m_cnt[k] < 2) : (m_cnt[k] == 0 || r_ordy[k])) && !m_halt[k];
        ov_e   = (m_cnt[k] > 0);
        exp    = pack(irdy_e, ov_e, m_q[k][0][31:0], m_q[k][0][32], m_halt[k],
                      16'(m_st[k]), 16'(m_sc[k]), ov_e);
        act    = (k == 0) ? pack_a(ov_e) : pack_b(ov_e);
        check($sformatf("rand%0d_cyc%0d", k, cyc), act, exp);

        in_f  = r_iv[k] && irdy_e;
        out_f = ov_e && r_ordy[k];
        if (ov_e && !r_ordy[k]) m_st[k] = (m_st[k] + 1 > maxc) ? maxc : m_st[k] + 1;
        if (r_sq[k]) begin
          m_sc[k]   = (m_sc[k] + m_cnt[k] - int'(out_f) > maxc) ? maxc
                                                                : m_sc[k] + m_cnt[k] - int'(out_f);
          m_cnt[k]  = 0;
          m_halt[k] = 0;
        end else begin
          if (out_f) begin
            m_q[k][0] = m_q[k][1];
            m_cnt[k]--;
          end
          if (in_f) begin
            m_q[k][m_cnt[k]] = {r_ih[k], r_id[k]};
            m_cnt[k]++;
            if (r_ih[k]) m_halt[k] = 1;
          end
        end
      end
    end

    @(negedge clk);
    idle_a(); idle_b();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
